// File: rtl/id_pkg.sv
// Shared definitions for the decode-stage operand path.
//   - Stop/NoStop encoding of the pipeline stall vector
//   - bit positions of the ID-in and EX-in stall lanes
//   - layout of one forwarding-bus entry: {we, ready, waddr, wdata}
package id_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam int ID_IN = 1;
  localparam int EX_IN = 2;

  localparam int DEF_AW     = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_FWD_W  = 2 + DEF_AW + DEF_DATA_W;

  function automatic int fwd_w(input int aw, input int dw);
    return 2 + aw + dw;
  endfunction

  // Field offsets inside one forwarding entry, wdata in the LSBs.
  function automatic int fwd_wdata_ofs();
    return 0;
  endfunction

  function automatic int fwd_waddr_ofs(input int dw);
    return dw;
  endfunction

  function automatic int fwd_ready_ofs(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int fwd_we_ofs(input int aw, input int dw);
    return aw + dw + 1;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// General-purpose register file for the decode stage.
//   i_clk              clock
//   i_we/i_waddr/i_wdata  write-back port (sync write, r0 never written)
//   i_raddr_a/o_rdata_a   async read port A
//   i_raddr_b/o_rdata_b   async read port B
// A write and a read of the same address in one cycle return the new data.
// Contents are deliberately not reset.
module id_regfile #(
  parameter int AW     = 5,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [AW-1:0]     i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [2**AW];
  logic              w_wr;

  assign w_wr = i_we && (i_waddr != '0);

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = (i_raddr_a == '0)                 ? '0      :
                     (w_wr && (i_waddr == i_raddr_a))  ? i_wdata :
                                                         r_mem[i_raddr_a];

  assign o_rdata_b = (i_raddr_b == '0)                 ? '0      :
                     (w_wr && (i_waddr == i_raddr_b))  ? i_wdata :
                                                         r_mem[i_raddr_b];

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage operand path: IF->ID pipeline register, instruction hold
// buffer, rs/rt operand resolution and load-use stall request.
//   clk, rst          clock, async active-high reset
//   stall             pipeline stall vector (bit 1 ID-in, bit 2 EX-in)
//   flush             squash the ID register
//   if_valid, if_pc   instruction address from IF
//   inst_sram_rdata   instruction word, one cycle after its PC
//   fwd_bus           NUM_FWD forwarding entries, source 0 (EX) in the LSBs
//   wb_*              write-back port into the register file
//   id_valid, id_pc, id_inst   live ID instruction
//   rs_data, rt_data  resolved operands
//   stallreq          load-use hazard on a live instruction
module id_operand_stage
  import id_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int AW      = 5,
  parameter int NUM_FWD = 2,
  parameter int STALL_W = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [STALL_W-1:0]                stall,
  input  logic                              flush,
  input  logic                              if_valid,
  input  logic [31:0]                       if_pc,
  input  logic [31:0]                       inst_sram_rdata,
  input  logic [NUM_FWD*(2+AW+DATA_W)-1:0]  fwd_bus,
  input  logic                              wb_we,
  input  logic [AW-1:0]                     wb_waddr,
  input  logic [DATA_W-1:0]                 wb_wdata,
  output logic                              id_valid,
  output logic [31:0]                       id_pc,
  output logic [31:0]                       id_inst,
  output logic [DATA_W-1:0]                 rs_data,
  output logic [DATA_W-1:0]                 rt_data,
  output logic                              stallreq
);

  localparam int FWD_W      = fwd_w(AW, DATA_W);
  localparam int WDATA_OFS  = fwd_wdata_ofs();
  localparam int WADDR_OFS  = fwd_waddr_ofs(DATA_W);
  localparam int READY_OFS  = fwd_ready_ofs(AW, DATA_W);
  localparam int WE_OFS     = fwd_we_ofs(AW, DATA_W);

  logic              r_id_valid;
  logic [31:0]       r_id_pc;
  logic              r_hold_valid;
  logic [31:0]       r_hold_inst;

  logic [31:0]       w_id_inst;
  logic [AW-1:0]     w_rs;
  logic [AW-1:0]     w_rt;
  logic [DATA_W-1:0] w_rf_rs;
  logic [DATA_W-1:0] w_rf_rt;
  logic [DATA_W:0]   w_res_rs;
  logic [DATA_W:0]   w_res_rt;
  logic              w_bubble;
  logic              w_load;
  logic              w_unused_stall;

  assign w_unused_stall = ^stall;

  assign w_bubble = (stall[ID_IN] == STOP) && (stall[EX_IN] == NOSTOP);
  assign w_load   = (stall[ID_IN] == NOSTOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_valid   <= 1'b0;
      r_id_pc      <= '0;
      r_hold_valid <= 1'b0;
      r_hold_inst  <= '0;
    end else if (flush || w_bubble) begin
      r_id_valid   <= 1'b0;
      r_id_pc      <= '0;
      r_hold_valid <= 1'b0;
    end else if (w_load) begin
      r_id_valid   <= if_valid;
      r_id_pc      <= if_pc;
      r_hold_valid <= 1'b0;
    end else if (!r_hold_valid) begin
      // ID is frozen; the SRAM output will move on, so keep the word here.
      r_hold_inst  <= w_id_inst;
      r_hold_valid <= 1'b1;
    end
  end

  assign w_id_inst = !r_id_valid  ? '0          :
                     r_hold_valid ? r_hold_inst :
                                    inst_sram_rdata;

  assign w_rs = AW'(w_id_inst[25:21]);
  assign w_rt = AW'(w_id_inst[20:16]);

  id_regfile #(
    .AW     (AW),
    .DATA_W (DATA_W)
  ) u_regfile (
    .i_clk     (clk),
    .i_we      (wb_we),
    .i_waddr   (wb_waddr),
    .i_wdata   (wb_wdata),
    .i_raddr_a (w_rs),
    .o_rdata_a (w_rf_rs),
    .i_raddr_b (w_rt),
    .o_rdata_b (w_rf_rt)
  );

  // Returns {hazard, value}. The register-file value already carries the
  // write-back bypass, so a forwarding hit naturally takes precedence.
  function automatic logic [DATA_W:0] resolve(
    input logic [AW-1:0]              addr,
    input logic [NUM_FWD*FWD_W-1:0]   bus,
    input logic [DATA_W-1:0]          rf
  );
    logic            found;
    logic [DATA_W:0] res;
    found = 1'b0;
    res   = {1'b0, rf};
    if (addr == '0) begin
      res = '0;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!found && bus[i*FWD_W+WE_OFS] &&
            (bus[i*FWD_W+WADDR_OFS +: AW] == addr)) begin
          found = 1'b1;
          res   = {~bus[i*FWD_W+READY_OFS], bus[i*FWD_W+WDATA_OFS +: DATA_W]};
        end
      end
    end
    return res;
  endfunction

  assign w_res_rs = resolve(w_rs, fwd_bus, w_rf_rs);
  assign w_res_rt = resolve(w_rt, fwd_bus, w_rf_rt);

  assign id_valid = r_id_valid;
  assign id_pc    = r_id_pc;
  assign id_inst  = w_id_inst;
  assign rs_data  = w_res_rs[DATA_W-1:0];
  assign rt_data  = w_res_rt[DATA_W-1:0];
  assign stallreq = r_id_valid & (w_res_rs[DATA_W] | w_res_rt[DATA_W]);

endmodule

// File: tb/tb_id_operand_stage.sv
module tb_id_operand_stage;

  localparam int DATA_W  = 32;
  localparam int AW      = 5;
  localparam int NUM_FWD = 2;
  localparam int STALL_W = 6;
  localparam int FW      = 2 + AW + DATA_W;

  logic                    clk;
  logic                    rst;
  logic [STALL_W-1:0]      stall;
  logic                    flush;
  logic                    if_valid;
  logic [31:0]             if_pc;
  logic [31:0]             inst_sram_rdata;
  logic [NUM_FWD*FW-1:0]   fwd_bus;
  logic                    wb_we;
  logic [AW-1:0]           wb_waddr;
  logic [DATA_W-1:0]       wb_wdata;
  logic                    id_valid;
  logic [31:0]             id_pc;
  logic [31:0]             id_inst;
  logic [DATA_W-1:0]       rs_data;
  logic [DATA_W-1:0]       rt_data;
  logic                    stallreq;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state for the randomized phase.
  logic [DATA_W-1:0] m_regs [32];
  logic              f_we  [NUM_FWD];
  logic              f_rdy [NUM_FWD];
  logic [AW-1:0]     f_adr [NUM_FWD];
  logic [DATA_W-1:0] f_dat [NUM_FWD];

  id_operand_stage #(
    .DATA_W (DATA_W), .AW (AW), .NUM_FWD (NUM_FWD), .STALL_W (STALL_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .inst_sram_rdata (inst_sram_rdata),
    .fwd_bus         (fwd_bus),
    .wb_we           (wb_we),
    .wb_waddr        (wb_waddr),
    .wb_wdata        (wb_wdata),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_inst         (id_inst),
    .rs_data         (rs_data),
    .rt_data         (rt_data),
    .stallreq        (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mk_fwd(input logic we, input logic rdy,
                                           input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    return {we, rdy, a, d};
  endfunction

  // Operand value and hazard as the rules describe them, from the bench's
  // own view of forwarding sources, write-back and register contents.
  task automatic ref_op(input logic [AW-1:0] a, output logic [DATA_W-1:0] v, output logic hz);
    bit hit;
    hit = 0;
    v   = '0;
    hz  = 1'b0;
    if (a != 0) begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!hit && f_we[i] && f_adr[i] == a) begin
          hit = 1;
          hz  = !f_rdy[i];
          v   = f_dat[i];
        end
      end
      if (!hit) v = (wb_we && wb_waddr == a) ? wb_wdata : m_regs[a];
    end
  endtask

  initial begin : main
    logic [31:0]       e_inst;
    logic              e_valid;
    logic [31:0]       e_pc;
    logic [DATA_W-1:0] v_rs, v_rt;
    logic              h_rs, h_rt;
    logic [31:0]       tmp;

    rst = 1'b1; stall = '0; flush = 1'b0; if_valid = 1'b0; if_pc = '0;
    inst_sram_rdata = '0; fwd_bus = '0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    #12;
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_stallreq", {31'b0, stallreq}, 32'd0);
    chk("rst_inst", id_inst, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Register file read through.
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h1234;
    if_valid = 1'b1; if_pc = 32'h100; inst_sram_rdata = 32'h00A53025;
    tick();
    wb_we = 1'b0;
    #1;
    chk("load_valid", {31'b0, id_valid}, 32'd1);
    chk("load_pc", id_pc, 32'h100);
    chk("load_inst", id_inst, 32'h00A53025);
    chk("rf_rs", rs_data, 32'h1234);
    chk("rf_rt", rt_data, 32'h1234);
    chk("rf_stallreq", {31'b0, stallreq}, 32'd0);
    wb_we = 1'b1; wb_wdata = 32'h5678;
    #1;
    chk("wb_bypass_rs", rs_data, 32'h5678);
    chk("wb_bypass_rt", rt_data, 32'h5678);
    tick();
    wb_we = 1'b0;
    #1;
    chk("rf_after_wr", rs_data, 32'h5678);

    // Forward priority and r0.
    inst_sram_rdata = 32'h01000000;
    fwd_bus = {mk_fwd(1, 1, 5'd8, 32'hBBBB), mk_fwd(1, 1, 5'd8, 32'hAAAA)};
    wb_we = 1'b1; wb_waddr = 5'd8; wb_wdata = 32'hCCCC;
    #1;
    chk("fwd0_wins", rs_data, 32'hAAAA);
    chk("r0_zero", rt_data, 32'd0);
    fwd_bus = {mk_fwd(1, 1, 5'd8, 32'hBBBB), mk_fwd(0, 1, 5'd8, 32'hAAAA)};
    #1;
    chk("fwd1_wins", rs_data, 32'hBBBB);
    fwd_bus = '0;
    #1;
    chk("wb_wins", rs_data, 32'hCCCC);
    tick();
    wb_we = 1'b0;
    #1;
    chk("rf_r8", rs_data, 32'hCCCC);

    // Load-use hazard and hold buffer.
    inst_sram_rdata = 32'h01200000;
    fwd_bus = {mk_fwd(0, 0, 5'd0, 32'h0), mk_fwd(1, 0, 5'd9, 32'h9999)};
    #1;
    chk("hazard_same_cycle", {31'b0, stallreq}, 32'd1);
    stall = 6'b000111;
    tick();
    inst_sram_rdata = 32'hDEADBEEF;
    #1;
    chk("hold_inst1", id_inst, 32'h01200000);
    chk("hold_stallreq", {31'b0, stallreq}, 32'd1);
    tick();
    chk("hold_inst2", id_inst, 32'h01200000);
    chk("hold_pc", id_pc, 32'h100);
    chk("hold_valid", {31'b0, id_valid}, 32'd1);
    fwd_bus = {mk_fwd(0, 0, 5'd0, 32'h0), mk_fwd(1, 1, 5'd9, 32'h9999)};
    #1;
    chk("ready_stallreq", {31'b0, stallreq}, 32'd0);
    chk("ready_rs", rs_data, 32'h9999);
    stall = '0; if_pc = 32'h104;
    tick();
    chk("release_inst", id_inst, 32'hDEADBEEF);
    chk("release_pc", id_pc, 32'h104);

    // Bubble insertion with a pending hazard.
    inst_sram_rdata = 32'h01200000;
    fwd_bus = {mk_fwd(0, 0, 5'd0, 32'h0), mk_fwd(1, 0, 5'd9, 32'h9999)};
    #1;
    chk("pre_bubble_haz", {31'b0, stallreq}, 32'd1);
    stall = 6'b000010;
    tick();
    chk("bubble_valid", {31'b0, id_valid}, 32'd0);
    chk("bubble_pc", id_pc, 32'd0);
    chk("bubble_stallreq", {31'b0, stallreq}, 32'd0);
    chk("bubble_inst", id_inst, 32'd0);

    // Flush beats stall and clears the hold buffer.
    stall = '0; if_pc = 32'h200; inst_sram_rdata = 32'h22222222; fwd_bus = '0;
    tick();
    chk("reload_pc", id_pc, 32'h200);
    stall = 6'b000111;
    tick();
    inst_sram_rdata = 32'h33333333;
    #1;
    chk("hold_again", id_inst, 32'h22222222);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", {31'b0, id_valid}, 32'd0);
    chk("flush_pc", id_pc, 32'd0);
    stall = '0; if_pc = 32'h204;
    tick();
    chk("flush_hold_clr", id_inst, 32'h33333333);
    chk("flush_reload_pc", id_pc, 32'h204);

    // Reset in the middle of a stall.
    stall = 6'b000111;
    tick();
    inst_sram_rdata = 32'h44444444;
    #1;
    chk("hold_pre_rst", id_inst, 32'h33333333);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_mid_pc", id_pc, 32'd0);
    chk("rst_mid_inst", id_inst, 32'd0);
    chk("rst_mid_stallreq", {31'b0, stallreq}, 32'd0);
    rst = 1'b0;
    stall = '0; if_pc = 32'h300;
    tick();
    chk("rst_hold_clr", id_inst, 32'h44444444);

    // Randomized phase: fill every register with a known value first.
    m_regs[0] = '0;
    if_valid = 1'b0;
    for (int i = 1; i < 32; i++) begin
      wb_we = 1'b1; wb_waddr = AW'(i); wb_wdata = $urandom;
      tick();
      m_regs[i] = wb_wdata;
    end
    wb_we = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      f_we[i] = 0; f_rdy[i] = 0; f_adr[i] = '0; f_dat[i] = '0;
    end

    for (int it = 0; it < 250; it++) begin
      if_valid = 1'($urandom_range(0, 3) != 0);
      if_pc    = $urandom;
      e_valid  = if_valid;
      e_pc     = if_pc;
      tick();
      if (wb_we && wb_waddr != 0) m_regs[wb_waddr] = wb_wdata;

      tmp = $urandom;
      tmp[25:21] = 5'($urandom_range(0, 7));
      tmp[20:16] = 5'($urandom_range(0, 7));
      inst_sram_rdata = tmp;
      for (int i = 0; i < NUM_FWD; i++) begin
        f_we[i]  = 1'($urandom_range(0, 1));
        f_rdy[i] = 1'($urandom_range(0, 3) != 0);
        f_adr[i] = AW'($urandom_range(0, 7));
        f_dat[i] = $urandom;
        fwd_bus[i*FW +: FW] = mk_fwd(f_we[i], f_rdy[i], f_adr[i], f_dat[i]);
      end
      wb_we    = 1'($urandom_range(0, 1));
      wb_waddr = AW'($urandom_range(0, 7));
      wb_wdata = $urandom;
      #1;

      e_inst = e_valid ? tmp : 32'd0;
      ref_op(e_inst[25:21], v_rs, h_rs);
      ref_op(e_inst[20:16], v_rt, h_rt);
      chk("rnd_valid", {31'b0, id_valid}, {31'b0, e_valid});
      chk("rnd_pc", id_pc, e_pc);
      chk("rnd_inst", id_inst, e_inst);
      chk("rnd_stallreq", {31'b0, stallreq}, {31'b0, e_valid & (h_rs | h_rt)});
      if (!h_rs) chk("rnd_rs", rs_data, v_rs);
      if (!h_rt) chk("rnd_rt", rt_data, v_rt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
